// File: rtl/y86_pipe_pkg.sv
// Shared Y86-64 pipeline constants: status codes, NOP icode, no-register ID
// and the per-edge action a stage register takes.
package y86_pipe_pkg;

  localparam logic [3:0] STAT_AOK  = 4'h1;
  localparam logic [3:0] STAT_HLT  = 4'h2;
  localparam logic [3:0] STAT_ADR  = 4'h3;
  localparam logic [3:0] STAT_INS  = 4'h4;
  localparam logic [3:0] STAT_BUB  = 4'h8;
  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] RNONE     = 4'hF;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } stage_act_e;

  function automatic logic is_exc_stat(input logic [3:0] stat);
    return (stat == STAT_HLT) || (stat == STAT_ADR) || (stat == STAT_INS);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter (sticks at all ones), synchronous active-high clear.
// One-cycle update latency; inc is sampled every edge, no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Y86-64 pipeline stage register with bubble/stall control, sticky exception freeze
// and stall/bubble counters; one-cycle latency, i_stall holds, frozen ignores controls.
module pipe_stage_reg
  import y86_pipe_pkg::*;
#(
  parameter int WORD_W        = 64,
  parameter int NUM_VAL       = 2,
  parameter int REGID_W       = 4,
  parameter int NUM_DST       = 2,
  parameter int CNT_W         = 16,
  parameter int FREEZE_ON_EXC = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_stall,
  input  logic                       i_bubble,
  input  logic [3:0]                 in_stat,
  input  logic [3:0]                 in_icode,
  input  logic [NUM_VAL*WORD_W-1:0]  in_val,
  input  logic [NUM_DST*REGID_W-1:0] in_dst,
  output logic [3:0]                 out_stat,
  output logic [3:0]                 out_icode,
  output logic [NUM_VAL*WORD_W-1:0]  out_val,
  output logic [NUM_DST*REGID_W-1:0] out_dst,
  output logic                       frozen,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           bubble_cnt
);

  localparam int VAL_W = NUM_VAL * WORD_W;
  localparam int DST_W = NUM_DST * REGID_W;

  stage_act_e         act;
  logic               stall_inc;
  logic               bubble_inc;

  logic [3:0]         stat_q,   stat_d;
  logic [3:0]         icode_q,  icode_d;
  logic [VAL_W-1:0]   val_q,    val_d;
  logic [DST_W-1:0]   dst_q,    dst_d;
  logic               frozen_q, frozen_d;

  // A frozen stage ignores both controls; bubble outranks stall.
  always_comb begin
    act        = ACT_LOAD;
    stall_inc  = 1'b0;
    bubble_inc = 1'b0;
    if (frozen_q) begin
      act = ACT_HOLD;
    end else if (i_bubble) begin
      act        = ACT_BUBBLE;
      bubble_inc = 1'b1;
    end else if (i_stall) begin
      act       = ACT_HOLD;
      stall_inc = 1'b1;
    end
  end

  always_comb begin
    stat_d   = stat_q;
    icode_d  = icode_q;
    val_d    = val_q;
    dst_d    = dst_q;
    frozen_d = frozen_q;
    case (act)
      ACT_BUBBLE: begin
        stat_d  = STAT_BUB;
        icode_d = ICODE_NOP;
        val_d   = '0;
        dst_d   = {DST_W{1'b1}};
      end
      ACT_LOAD: begin
        stat_d  = in_stat;
        icode_d = in_icode;
        val_d   = in_val;
        dst_d   = in_dst;
        if ((FREEZE_ON_EXC != 0) && is_exc_stat(in_stat)) begin
          frozen_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q   <= STAT_BUB;
      icode_q  <= ICODE_NOP;
      val_q    <= '0;
      dst_q    <= {DST_W{1'b1}};
      frozen_q <= 1'b0;
    end else begin
      stat_q   <= stat_d;
      icode_q  <= icode_d;
      val_q    <= val_d;
      dst_q    <= dst_d;
      frozen_q <= frozen_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

  assign out_stat  = stat_q;
  assign out_icode = icode_q;
  assign out_val   = val_q;
  assign out_dst   = dst_q;
  assign frozen    = frozen_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: three instances (default, no freeze, 2-bit counters)
// share stimulus; each directed step pushes the hand-computed expectation for one instance.
module tb_pipe_stage_reg;
  import y86_pipe_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_stall = 1'b0;
  logic         i_bubble = 1'b0;
  logic [3:0]   in_stat = STAT_AOK;
  logic [3:0]   in_icode = ICODE_NOP;
  logic [127:0] in_val = '0;
  logic [7:0]   in_dst = {RNONE, RNONE};

  logic [3:0]   a_stat, b_stat, c_stat;
  logic [3:0]   a_icode, b_icode, c_icode;
  logic [127:0] a_val, b_val, c_val;
  logic [7:0]   a_dst, b_dst, c_dst;
  logic         a_frz, b_frz, c_frz;
  logic [15:0]  a_sc, a_bc, b_sc, b_bc;
  logic [1:0]   c_sc, c_bc;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WORD_W(64), .NUM_VAL(2), .REGID_W(4), .NUM_DST(2), .CNT_W(16), .FREEZE_ON_EXC(1)) dut_a (
    .clk(clk), .reset(reset), .i_stall(i_stall), .i_bubble(i_bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_val(in_val), .in_dst(in_dst),
    .out_stat(a_stat), .out_icode(a_icode), .out_val(a_val), .out_dst(a_dst),
    .frozen(a_frz), .stall_cnt(a_sc), .bubble_cnt(a_bc));

  pipe_stage_reg #(.WORD_W(64), .NUM_VAL(2), .REGID_W(4), .NUM_DST(2), .CNT_W(16), .FREEZE_ON_EXC(0)) dut_b (
    .clk(clk), .reset(reset), .i_stall(i_stall), .i_bubble(i_bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_val(in_val), .in_dst(in_dst),
    .out_stat(b_stat), .out_icode(b_icode), .out_val(b_val), .out_dst(b_dst),
    .frozen(b_frz), .stall_cnt(b_sc), .bubble_cnt(b_bc));

  pipe_stage_reg #(.WORD_W(64), .NUM_VAL(2), .REGID_W(4), .NUM_DST(2), .CNT_W(2), .FREEZE_ON_EXC(1)) dut_c (
    .clk(clk), .reset(reset), .i_stall(i_stall), .i_bubble(i_bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_val(in_val), .in_dst(in_dst),
    .out_stat(c_stat), .out_icode(c_icode), .out_val(c_val), .out_dst(c_dst),
    .frozen(c_frz), .stall_cnt(c_sc), .bubble_cnt(c_bc));

  typedef struct {
    int           step;
    int           sel;
    logic [3:0]   stat;
    logic [3:0]   icode;
    logic [127:0] val;
    logic [7:0]   dst;
    logic         frz;
    logic [15:0]  sc;
    logic [15:0]  bc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  function automatic exp_t ex(input int sel, input logic [3:0] st, input logic [3:0] ic,
                              input logic [63:0] v0, input logic [63:0] v1,
                              input logic [3:0] d0, input logic [3:0] d1,
                              input logic frz, input int sc, input int bc);
    exp_t e;
    e.step  = 0;
    e.sel   = sel;
    e.stat  = st;
    e.icode = ic;
    e.val   = {v1, v0};
    e.dst   = {d1, d0};
    e.frz   = frz;
    e.sc    = 16'(sc);
    e.bc    = 16'(bc);
    return e;
  endfunction

  function automatic exp_t exb(input int sel, input int sc, input int bc);
    return ex(sel, 4'h8, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, sc, bc);
  endfunction

  task automatic step(input logic rst, input logic stl, input logic bub,
                      input logic [3:0] st, input logic [3:0] ic,
                      input logic [63:0] v0, input logic [63:0] v1,
                      input logic [3:0] d0, input logic [3:0] d1, input exp_t e);
    exp_t ee;
    @(negedge clk);
    reset    = rst;
    i_stall  = stl;
    i_bubble = bub;
    in_stat  = st;
    in_icode = ic;
    in_val   = {v1, v0};
    in_dst   = {d1, d0};
    step_no++;
    ee      = e;
    ee.step = step_no;
    sb.push_back(ee);
  endtask

  task automatic cmp(input int stp, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", stp, name, act, exp);
    end
  endtask

  // Monitor: every edge that follows a driven step presents one registered result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        case (e.sel)
          0: begin
            cmp(e.step, "stat", 128'(a_stat), 128'(e.stat));
            cmp(e.step, "icode", 128'(a_icode), 128'(e.icode));
            cmp(e.step, "val", a_val, e.val);
            cmp(e.step, "dst", 128'(a_dst), 128'(e.dst));
            cmp(e.step, "frozen", 128'(a_frz), 128'(e.frz));
            cmp(e.step, "stall_cnt", 128'(a_sc), 128'(e.sc));
            cmp(e.step, "bubble_cnt", 128'(a_bc), 128'(e.bc));
          end
          1: begin
            cmp(e.step, "stat", 128'(b_stat), 128'(e.stat));
            cmp(e.step, "icode", 128'(b_icode), 128'(e.icode));
            cmp(e.step, "val", b_val, e.val);
            cmp(e.step, "dst", 128'(b_dst), 128'(e.dst));
            cmp(e.step, "frozen", 128'(b_frz), 128'(e.frz));
            cmp(e.step, "stall_cnt", 128'(b_sc), 128'(e.sc));
            cmp(e.step, "bubble_cnt", 128'(b_bc), 128'(e.bc));
          end
          default: begin
            cmp(e.step, "stat", 128'(c_stat), 128'(e.stat));
            cmp(e.step, "icode", 128'(c_icode), 128'(e.icode));
            cmp(e.step, "val", c_val, e.val);
            cmp(e.step, "dst", 128'(c_dst), 128'(e.dst));
            cmp(e.step, "frozen", 128'(c_frz), 128'(e.frz));
            cmp(e.step, "stall_cnt", 128'(c_sc), 128'(e.sc));
            cmp(e.step, "bubble_cnt", 128'(c_bc), 128'(e.bc));
          end
        endcase
      end
    end
  end

  initial begin
    logic [63:0] r0, r1;
    r0 = {$urandom, $urandom};
    r1 = {$urandom, $urandom};

    // Reset with random inputs, then normal load.
    step(1, 1, 1, 4'($urandom), 4'($urandom), r0, r1, 4'($urandom), 4'($urandom), exb(0, 0, 0));
    step(0, 0, 0, 4'h1, 4'h6, 64'h1234, 64'hABCD, 4'h3, 4'hF, ex(0, 1, 6, 64'h1234, 64'hABCD, 3, 15, 0, 0, 0));
    // Three stalls with changing inputs (an exception code seen while stalled must not freeze).
    step(0, 1, 0, 4'h1, 4'h2, 64'h11, 64'h22, 4'h1, 4'h2, ex(0, 1, 6, 64'h1234, 64'hABCD, 3, 15, 0, 1, 0));
    step(0, 1, 0, 4'h3, 4'h3, 64'h33, 64'h44, 4'h5, 4'h6, ex(0, 1, 6, 64'h1234, 64'hABCD, 3, 15, 0, 2, 0));
    step(0, 1, 0, 4'h4, 4'h4, 64'h55, 64'h66, 4'h7, 4'h8, ex(0, 1, 6, 64'h1234, 64'hABCD, 3, 15, 0, 3, 0));
    step(0, 0, 0, 4'h1, 4'h5, 64'h77, 64'h88, 4'h9, 4'hA, ex(0, 1, 5, 64'h77, 64'h88, 9, 10, 0, 3, 0));
    // Bubble beats stall; a bubble over an exception input does not freeze.
    step(0, 1, 1, 4'h1, 4'h6, 64'h1, 64'h2, 4'h1, 4'h1, exb(0, 3, 1));
    step(0, 0, 1, 4'h2, 4'h0, 64'h3, 64'h4, 4'h2, 4'h2, exb(0, 3, 2));
    // Unlisted status code passes through.
    step(0, 0, 0, 4'h5, 4'h7, 64'h99, 64'hAA, 4'h2, 4'h3, ex(0, 5, 7, 64'h99, 64'hAA, 2, 3, 0, 3, 2));
    // HLT captured: frozen on the same edge, then every control ignored.
    step(0, 0, 0, 4'h2, 4'h0, 64'hAA, 64'hBB, 4'h5, 4'h6, ex(0, 2, 0, 64'hAA, 64'hBB, 5, 6, 1, 3, 2));
    step(0, 0, 0, 4'h1, 4'h6, 64'h1, 64'h2, 4'h3, 4'h4, ex(0, 2, 0, 64'hAA, 64'hBB, 5, 6, 1, 3, 2));
    step(0, 1, 0, 4'h1, 4'h6, 64'h1, 64'h2, 4'h3, 4'h4, ex(0, 2, 0, 64'hAA, 64'hBB, 5, 6, 1, 3, 2));
    step(0, 0, 1, 4'h1, 4'h6, 64'h1, 64'h2, 4'h3, 4'h4, ex(0, 2, 0, 64'hAA, 64'hBB, 5, 6, 1, 3, 2));
    step(0, 1, 1, 4'h1, 4'h6, 64'h1, 64'h2, 4'h3, 4'h4, ex(0, 2, 0, 64'hAA, 64'hBB, 5, 6, 1, 3, 2));
    // Reset while frozen with controls high wins; next cycle is a normal load.
    step(1, 1, 1, 4'h1, 4'h6, 64'h1, 64'h2, 4'h3, 4'h4, exb(0, 0, 0));
    step(0, 0, 0, 4'h1, 4'h3, 64'hC, 64'hD, 4'h1, 4'h2, ex(0, 1, 3, 64'hC, 64'hD, 1, 2, 0, 0, 0));
    // Reset mid-stall.
    step(0, 1, 0, 4'h1, 4'h9, 64'h5, 64'h6, 4'h7, 4'h8, ex(0, 1, 3, 64'hC, 64'hD, 1, 2, 0, 1, 0));
    step(1, 1, 0, 4'h1, 4'h9, 64'h5, 64'h6, 4'h7, 4'h8, exb(0, 0, 0));
    // INS and ADR also freeze.
    step(0, 0, 0, 4'h4, 4'hC, 64'hE, 64'hF, 4'hA, 4'hB, ex(0, 4, 12, 64'hE, 64'hF, 10, 11, 1, 0, 0));
    step(1, 0, 0, 4'h4, 4'hC, 64'hE, 64'hF, 4'hA, 4'hB, exb(0, 0, 0));
    step(0, 0, 0, 4'h3, 4'h2, 64'h10, 64'h20, 4'h0, 4'h1, ex(0, 3, 2, 64'h10, 64'h20, 0, 1, 1, 0, 0));
    step(0, 0, 0, 4'h1, 4'h2, 64'h30, 64'h40, 4'h2, 4'h3, ex(0, 3, 2, 64'h10, 64'h20, 0, 1, 1, 0, 0));

    // No-freeze instance: HLT passes through and the stage keeps loading.
    step(1, 0, 0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 4'h0, exb(1, 0, 0));
    step(0, 0, 0, 4'h2, 4'h0, 64'hAA, 64'hBB, 4'h5, 4'h6, ex(1, 2, 0, 64'hAA, 64'hBB, 5, 6, 0, 0, 0));
    step(0, 0, 0, 4'h1, 4'h6, 64'h1, 64'h2, 4'h3, 4'h4, ex(1, 1, 6, 64'h1, 64'h2, 3, 4, 0, 0, 0));
    step(0, 0, 1, 4'h1, 4'h6, 64'h1, 64'h2, 4'h3, 4'h4, exb(1, 0, 1));

    // 2-bit counters saturate at 3.
    step(1, 0, 0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 4'h0, exb(2, 0, 0));
    step(0, 1, 0, 4'h1, 4'h6, 64'h1, 64'h2, 4'h3, 4'h4, exb(2, 1, 0));
    step(0, 1, 0, 4'h1, 4'h6, 64'h1, 64'h2, 4'h3, 4'h4, exb(2, 2, 0));
    step(0, 1, 0, 4'h1, 4'h6, 64'h1, 64'h2, 4'h3, 4'h4, exb(2, 3, 0));
    step(0, 1, 0, 4'h1, 4'h6, 64'h1, 64'h2, 4'h3, 4'h4, exb(2, 3, 0));
    step(0, 1, 0, 4'h1, 4'h6, 64'h1, 64'h2, 4'h3, 4'h4, exb(2, 3, 0));
    step(0, 0, 1, 4'h1, 4'h6, 64'h1, 64'h2, 4'h3, 4'h4, exb(2, 3, 1));
    step(0, 0, 0, 4'h1, 4'h6, 64'h1, 64'h2, 4'h3, 4'h4, ex(2, 1, 6, 64'h1, 64'h2, 3, 4, 0, 3, 1));

    @(negedge clk);
    i_stall  = 1'b0;
    i_bubble = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
